// File: rtl/cory_demux8.sv
// cory_demux8: stream 1:8 demultiplexer with a one-entry register stage per output lane.
module cory_demux8 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    output logic         o_a_r,
    input  logic         i_s_v,
    input  logic [2:0]   i_s_d,
    output logic         o_s_r,
    output logic         o_z0_v,
    output logic [N-1:0] o_z0_d,
    input  logic         i_z0_r,
    output logic         o_z1_v,
    output logic [N-1:0] o_z1_d,
    input  logic         i_z1_r,
    output logic         o_z2_v,
    output logic [N-1:0] o_z2_d,
    input  logic         i_z2_r,
    output logic         o_z3_v,
    output logic [N-1:0] o_z3_d,
    input  logic         i_z3_r,
    output logic         o_z4_v,
    output logic [N-1:0] o_z4_d,
    input  logic         i_z4_r,
    output logic         o_z5_v,
    output logic [N-1:0] o_z5_d,
    input  logic         i_z5_r,
    output logic         o_z6_v,
    output logic [N-1:0] o_z6_d,
    input  logic         i_z6_r,
    output logic         o_z7_v,
    output logic [N-1:0] o_z7_d,
    input  logic         i_z7_r
);
    logic [7:0]   v;
    logic [N-1:0] d [8];
    logic [7:0]   z_r;
    logic [7:0]   lane_free;
    logic         sel_free;
    logic         accept;

    assign z_r       = {i_z7_r, i_z6_r, i_z5_r, i_z4_r, i_z3_r, i_z2_r, i_z1_r, i_z0_r};
    assign lane_free = ~v | z_r;
    assign sel_free  = lane_free[i_s_d];
    // a and s are only ever consumed together, so each ready looks at the other valid
    assign o_a_r     = i_s_v && sel_free;
    assign o_s_r     = i_a_v && sel_free;
    assign accept    = i_a_v && i_s_v && sel_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int k = 0; k < 8; k++) d[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (accept && i_s_d == 3'(k)) begin
                    v[k] <= 1'b1;
                    d[k] <= i_a_d;
                end else if (z_r[k]) begin
                    v[k] <= 1'b0;
                end
            end
        end
    end

    assign o_z0_v = v[0];
    assign o_z1_v = v[1];
    assign o_z2_v = v[2];
    assign o_z3_v = v[3];
    assign o_z4_v = v[4];
    assign o_z5_v = v[5];
    assign o_z6_v = v[6];
    assign o_z7_v = v[7];
    assign o_z0_d = d[0];
    assign o_z1_d = d[1];
    assign o_z2_d = d[2];
    assign o_z3_d = d[3];
    assign o_z4_d = d[4];
    assign o_z5_d = d[5];
    assign o_z6_d = d[6];
    assign o_z7_d = d[7];
endmodule
